blk_alloc_ctrl: RTL and testbench

- Sits directly upstream of the block memory manager, on the write side of each input port.
- Accepts a per-packet allocation request with a length in words and converts it to a block count.
- Checks the count against the manager's free-block count, then runs one occupy handshake per block.
- Queues the granted block addresses in a small FWFT FIFO for the write datapath, tagging the packet's last block.

---
 rtl/blk_alloc_ctrl.sv | 129 ++++++++++++
 tb/tb_blk_alloc_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_alloc_ctrl.sv
// blk_alloc_ctrl: converts packet length to blocks, occupies them one by one and queues addresses in an FWFT FIFO
module blk_alloc_ctrl #(
  parameter int AWIDTH      = 10,
  parameter int LEN_WIDTH   = 11,
  parameter int BW_LOG2     = 3,
  parameter int MAX_BLOCKS  = 128,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_req,
  input  logic [LEN_WIDTH-1:0]          alloc_len,
  output logic                          alloc_busy,
  output logic                          alloc_done,
  output logic                          alloc_rej,
  output logic                          alloc_err,
  output logic                          ocp_req,
  input  logic                          ocp_vld,
  input  logic [AWIDTH-1:0]             ocp_block_addr,
  input  logic [AWIDTH:0]               emp_block_num,
  input  logic                          mgr_full,
  output logic [AWIDTH-1:0]             addr_out,
  output logic                          addr_last,
  output logic                          addr_vld,
  input  logic                          addr_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  localparam int NBW = LEN_WIDTH + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, DONE, ERR} state_t;
  state_t          state, state_nx;
  logic [NBW-1:0]  nblk, nblk_in, blk_cnt, blk_cnt_nx;
  logic [TW-1:0]   tmo, tmo_nx;
  logic            ocp_nx, busy_nx, done_nx, rej_nx, err_nx;
  logic            push, pop, last, reject, full;
  logic [AWIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  assign nblk_in  = ({1'b0, alloc_len} + NBW'(2 ** BW_LOG2 - 1)) >> BW_LOG2;
  assign reject   = nblk == '0 || 32'(nblk) > 32'(MAX_BLOCKS) || 32'(nblk) > 32'(emp_block_num) || mgr_full;
  assign last     = blk_cnt == nblk - NBW'(1);
  assign full     = fifo_cnt == CW'(FIFO_DEPTH);
  assign pop      = addr_vld && addr_rdy;
  assign addr_vld = fifo_cnt != '0;
  assign addr_out  = mem[rd_ptr][AWIDTH:1];
  assign addr_last = mem[rd_ptr][0];
  always_comb begin
    state_nx   = state;
    ocp_nx     = 1'b0;
    busy_nx    = alloc_busy;
    done_nx    = 1'b0;
    rej_nx     = 1'b0;
    err_nx     = alloc_err;
    blk_cnt_nx = blk_cnt;
    tmo_nx     = tmo;
    push       = 1'b0;
    case (state)
      IDLE: if (alloc_req) begin
        state_nx = CHECK;
        busy_nx  = 1'b1;
      end
      CHECK: if (reject) begin
        state_nx = IDLE;
        rej_nx   = 1'b1;
        busy_nx  = 1'b0;
      end else begin
        state_nx   = REQ;
        blk_cnt_nx = '0;
      end
      REQ: if (!full) begin
        state_nx = WAIT;
        ocp_nx   = 1'b1;
        tmo_nx   = '0;
      end
      WAIT: if (ocp_vld) begin
        push       = 1'b1;
        blk_cnt_nx = blk_cnt + NBW'(1);
        state_nx   = last ? DONE : REQ;
      end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
        state_nx = ERR;
        err_nx   = 1'b1;
      end else begin
        ocp_nx = 1'b1;
        tmo_nx = tmo + TW'(1);
      end
      DONE: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
      end
      ERR: state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      nblk       <= '0;
      blk_cnt    <= '0;
      tmo        <= '0;
      ocp_req    <= 1'b0;
      alloc_busy <= 1'b0;
      alloc_done <= 1'b0;
      alloc_rej  <= 1'b0;
      alloc_err  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nx;
      blk_cnt    <= blk_cnt_nx;
      tmo        <= tmo_nx;
      ocp_req    <= ocp_nx;
      alloc_busy <= busy_nx;
      alloc_done <= done_nx;
      alloc_rej  <= rej_nx;
      alloc_err  <= err_nx;
      if (state == IDLE && alloc_req) nblk <= nblk_in;
      if (push) begin
        mem[wr_ptr] <= {ocp_block_addr, last};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_blk_alloc_ctrl.sv
// tb_blk_alloc_ctrl: directed tests with a queue-based address model checked every cycle
module tb_blk_alloc_ctrl;
  localparam int AW = 10, LW = 11, DEPTH = 8;
  logic clk = 0, rst_n = 0, alloc_req = 0, ocp_vld = 0, mgr_full = 0, addr_rdy = 1;
  logic [LW-1:0] alloc_len = '0;
  logic [AW-1:0] ocp_block_addr = '0;
  logic [AW:0]   emp_block_num = '0;
  logic alloc_busy, alloc_done, alloc_rej, alloc_err, ocp_req, addr_last, addr_vld;
  logic [AW-1:0] addr_out;
  logic [3:0]    fifo_cnt;
  typedef struct {logic [AW-1:0] a; logic l;} ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;
  int gcount = 0, exp_nblk = 1;
  int done_n = 0, rej_n = 0, push_n = 0, req_hi_n = 0, pop_n = 0, last_n = 0;
  logic [AW-1:0] base = '0;
  logic mgr_on = 1, force_vld = 0;

  blk_alloc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_len(alloc_len),
    .alloc_busy(alloc_busy), .alloc_done(alloc_done), .alloc_rej(alloc_rej), .alloc_err(alloc_err),
    .ocp_req(ocp_req), .ocp_vld(ocp_vld), .ocp_block_addr(ocp_block_addr),
    .emp_block_num(emp_block_num), .mgr_full(mgr_full),
    .addr_out(addr_out), .addr_last(addr_last), .addr_vld(addr_vld), .addr_rdy(addr_rdy),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: grants answer ocp_req at once; FIFO contents kept as a queue with per-packet last tagging
  initial forever begin
    logic pop;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      gcount = 0;
    end
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("addr_vld", addr_vld, q.size() != 0);
    if (q.size() != 0) begin
      chk("addr_out", addr_out, q[0].a);
      chk("addr_last", addr_last, q[0].l);
    end
    if (ocp_req) begin
      chk("req_room", q.size() < DEPTH, 1);
      req_hi_n++;
    end
    if (alloc_req && !alloc_err) chk("req_while_busy", alloc_busy, 0);
    done_n += int'(alloc_done);
    rej_n  += int'(alloc_rej);
    if (rst_n) begin
      pop = q.size() != 0 && addr_rdy;
      if (addr_vld && addr_rdy) begin
        pop_n++;
        last_n += int'(addr_last);
      end
      if (ocp_req && ocp_vld) begin
        q.push_back('{a: ocp_block_addr, l: (gcount == exp_nblk - 1)});
        push_n++;
        gcount = (gcount == exp_nblk - 1) ? 0 : gcount + 1;
      end
      if (pop) void'(q.pop_front());
    end
    @(posedge clk);
    #2;
    ocp_vld = force_vld | (mgr_on & ocp_req & rst_n);
    ocp_block_addr = force_vld ? 10'h3ff : base + AW'(gcount);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {alloc_busy, alloc_done, alloc_rej, alloc_err, ocp_req, addr_vld, addr_last}, 0);
    chk({tag, "_addr"}, addr_out, 0);
    chk({tag, "_cnt"}, fifo_cnt, 0);
  endtask

  task automatic run_pkt(input int len, input int emp, input logic full, input int exp_blocks, input string tag);
    int d0, r0, p0, l0, u0, k;
    d0 = done_n; r0 = rej_n; p0 = pop_n; l0 = last_n; u0 = push_n;
    exp_nblk = (len + 7) / 8;
    emp_block_num = (AW+1)'(emp);
    mgr_full = full;
    alloc_len = LW'(len);
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    k = 0;
    while (done_n == d0 && rej_n == r0 && k < 2000) begin
      cyc(1);
      k++;
    end
    cyc(3);
    chk({tag, "_done"}, done_n - d0, exp_blocks != 0);
    chk({tag, "_rej"}, rej_n - r0, exp_blocks == 0);
    chk({tag, "_grants"}, push_n - u0, exp_blocks);
    chk({tag, "_pops"}, pop_n - p0, exp_blocks);
    chk({tag, "_lasts"}, last_n - l0, exp_blocks != 0);
  endtask

  task automatic rej_timing(input int len, input int emp, input logic full, input string tag);
    int h0, u0;
    h0 = req_hi_n; u0 = push_n;
    emp_block_num = (AW+1)'(emp);
    mgr_full = full;
    alloc_len = LW'(len);
    alloc_req = 1;
    @(negedge clk);
    chk({tag, "_n0"}, {alloc_busy, alloc_rej}, 2'b00);
    cyc(1);
    alloc_req = 0;
    @(negedge clk);
    chk({tag, "_n1"}, {alloc_busy, alloc_rej}, 2'b10);
    @(negedge clk);
    chk({tag, "_n2"}, {alloc_busy, alloc_rej}, 2'b01);
    @(negedge clk);
    chk({tag, "_n3"}, alloc_rej, 0);
    chk({tag, "_noreq"}, req_hi_n - h0, 0);
    chk({tag, "_nogrant"}, push_n - u0, 0);
    cyc(1);
    mgr_full = 0;
  endtask

  initial begin
    int k, d0, h0, p0, l0, u0;
    rst_n = 0;
    cyc(2);
    @(negedge clk);
    check_zero("reset");
    cyc(1);
    rst_n = 1;
    cyc(2);

    // three-block packet with literal address and latency pins
    base = 10'h005; exp_nblk = 3; emp_block_num = 100; alloc_len = 20;
    d0 = done_n; h0 = req_hi_n; p0 = pop_n; l0 = last_n;
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    k = 1;
    while (k < 50) begin
      @(negedge clk);
      if (alloc_done) break;
      if (k == 4) chk("t1_a0", {addr_out, addr_last}, {10'h005, 1'b0});
      if (k == 6) chk("t1_a1", {addr_out, addr_last}, {10'h006, 1'b0});
      if (k == 8) chk("t1_a2", {addr_out, addr_last}, {10'h007, 1'b1});
      k++;
    end
    chk("t1_latency", k, 9);
    chk("t1_req_cycles", req_hi_n - h0, 3);
    cyc(3);
    chk("t1_done", done_n - d0, 1);
    chk("t1_pops", pop_n - p0, 3);
    chk("t1_lasts", last_n - l0, 1);

    base = 10'h100;
    rej_timing(0, 100, 0, "len0");
    rej_timing(1025, 200, 0, "len1025");
    rej_timing(16, 1, 0, "nofree");
    rej_timing(8, 100, 1, "mgrfull");
    run_pkt(16, 2, 0, 2, "exact_free");
    run_pkt(1024, 200, 0, 128, "max_blocks");

    // backpressure: FIFO fills at 8 then the rest follow once drained
    base = 10'h040; exp_nblk = 10; emp_block_num = 100; alloc_len = 80; addr_rdy = 0;
    d0 = done_n; p0 = pop_n; l0 = last_n; u0 = push_n;
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    cyc(3);
    emp_block_num = 0;
    cyc(40);
    chk("bp_cnt", fifo_cnt, 8);
    chk("bp_req", ocp_req, 0);
    chk("bp_grants", push_n - u0, 8);
    chk("bp_head", {addr_out, addr_last}, {10'h040, 1'b0});
    h0 = req_hi_n;
    cyc(10);
    chk("bp_req_held", req_hi_n - h0, 0);
    addr_rdy = 1;
    k = 0;
    while (done_n == d0 && k < 200) begin
      cyc(1);
      k++;
    end
    cyc(3);
    chk("bp_done", done_n - d0, 1);
    chk("bp_pops", pop_n - p0, 10);
    chk("bp_lasts", last_n - l0, 1);

    base = 10'h200;
    run_pkt(8, 100, 0, 1, "len8");
    run_pkt(9, 100, 0, 2, "len9");

    // reset while waiting for a grant, then a stray grant
    mgr_on = 0; exp_nblk = 2; emp_block_num = 100; alloc_len = 16;
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    k = 0;
    while (!ocp_req && k < 20) begin
      cyc(1);
      k++;
    end
    chk("rst_wait_req", ocp_req, 1);
    rst_n = 0;
    #1;
    chk("rst_req_drop", ocp_req, 0);
    chk("rst_busy", alloc_busy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    force_vld = 1;
    cyc(2);
    rst_n = 1;
    cyc(2);
    force_vld = 0;
    cyc(2);
    check_zero("late_grant");

    // grant withheld: timeout after 64 cycles of ocp_req, then stuck until reset
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    k = 0;
    while (!ocp_req && k < 20) begin
      cyc(1);
      k++;
    end
    k = 0;
    while (ocp_req && k < 200) begin
      cyc(1);
      k++;
    end
    chk("tmo_cycles", k, 64);
    chk("tmo_err", {alloc_err, alloc_busy, ocp_req}, 3'b110);
    mgr_on = 1;
    d0 = done_n; h0 = req_hi_n;
    alloc_len = 8;
    alloc_req = 1;
    cyc(1);
    alloc_req = 0;
    cyc(10);
    chk("err_sticky", {alloc_err, alloc_busy, ocp_req}, 3'b110);
    chk("err_ignored", (req_hi_n - h0) + (done_n - d0), 0);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    cyc(1);
    check_zero("err_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
